// File: rtl/alu_operand_ctrl.sv
// alu_operand_ctrl: execute-stage operand-select control for riscv_core.
// Decodes the EX instruction into ALU operand mux selects, forwards the
// writeback result on RAW hazards and stalls EX while load data is pending.
// A bounded wait counter abandons loads whose data never arrives.

`ifndef ALU_IN_MUX_SEL_WIDTH
`define ALU_IN_MUX_SEL_WIDTH 3
`endif
`ifndef ALU_IN_MUX_RF
`define ALU_IN_MUX_RF     3'd0
`define ALU_IN_MUX_PC     3'd1
`define ALU_IN_MUX_NULL   3'd2
`define ALU_IN_MUX_IMM_U  3'd3
`define ALU_IN_MUX_IMM_UJ 3'd4
`define ALU_IN_MUX_IMM_I  3'd5
`define ALU_IN_MUX_IMM_S  3'd6
`define ALU_IN_MUX_FW_WB  3'd7
`endif

module alu_operand_ctrl #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_WIDTH    = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [31:0]                       ex_instruction,
  input  logic                              ex_valid,
  input  logic                              dmem_valid,
  output logic [`ALU_IN_MUX_SEL_WIDTH-1:0]  mux_1_sel,
  output logic [`ALU_IN_MUX_SEL_WIDTH-1:0]  mux_2_sel,
  output logic                              fw_rs1,
  output logic                              fw_rs2,
  output logic                              stall,
  output logic                              illegal_op,
  output logic                              load_timeout
);

  localparam int SW = `ALU_IN_MUX_SEL_WIDTH;

  // RV32I base opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // FSM states
  localparam logic RUN       = 1'b0;
  localparam logic LOAD_WAIT = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LOAD_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd_field;
  logic [4:0] rs_field [2];

  assign opcode      = ex_instruction[6:0];
  assign rd_field    = ex_instruction[11:7];
  assign rs_field[0] = ex_instruction[19:15];
  assign rs_field[1] = ex_instruction[24:20];

  // funct3/funct7 do not influence operand selection
  logic unused_fields;
  assign unused_fields = ^{ex_instruction[31:25], ex_instruction[14:12]};

  // Registered state
  logic                 state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 wb_valid_reg, wb_valid_next;
  logic                 wb_we_reg, wb_we_next;
  logic                 wb_load_reg, wb_load_next;
  logic [4:0]           wb_rd_reg, wb_rd_next;
  logic                 load_timeout_reg, load_timeout_next;

  // Decode results
  logic [SW-1:0] base_sel [2];
  logic          dec_illegal;
  logic          dec_writes_rd;
  logic          dec_load;

  // Base operand decode by opcode; unknown opcodes select NULL and flag illegal
  always_comb begin
    base_sel[0]   = `ALU_IN_MUX_NULL;
    base_sel[1]   = `ALU_IN_MUX_NULL;
    dec_illegal   = 1'b0;
    dec_writes_rd = 1'b0;
    dec_load      = 1'b0;
    case (opcode)
      OPC_LUI: begin
        base_sel[0]   = `ALU_IN_MUX_NULL;
        base_sel[1]   = `ALU_IN_MUX_IMM_U;
        dec_writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        base_sel[0]   = `ALU_IN_MUX_PC;
        base_sel[1]   = `ALU_IN_MUX_IMM_U;
        dec_writes_rd = 1'b1;
      end
      OPC_JAL: begin
        base_sel[0]   = `ALU_IN_MUX_PC;
        base_sel[1]   = `ALU_IN_MUX_IMM_UJ;
        dec_writes_rd = 1'b1;
      end
      OPC_JALR: begin
        base_sel[0]   = `ALU_IN_MUX_RF;
        base_sel[1]   = `ALU_IN_MUX_IMM_I;
        dec_writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        base_sel[0]   = `ALU_IN_MUX_RF;
        base_sel[1]   = `ALU_IN_MUX_RF;
      end
      OPC_LOAD: begin
        base_sel[0]   = `ALU_IN_MUX_RF;
        base_sel[1]   = `ALU_IN_MUX_IMM_I;
        dec_writes_rd = 1'b1;
        dec_load      = 1'b1;
      end
      OPC_STORE: begin
        base_sel[0]   = `ALU_IN_MUX_RF;
        base_sel[1]   = `ALU_IN_MUX_IMM_S;
      end
      OPC_OPIMM: begin
        base_sel[0]   = `ALU_IN_MUX_RF;
        base_sel[1]   = `ALU_IN_MUX_IMM_I;
        dec_writes_rd = 1'b1;
      end
      OPC_OP: begin
        base_sel[0]   = `ALU_IN_MUX_RF;
        base_sel[1]   = `ALU_IN_MUX_RF;
        dec_writes_rd = 1'b1;
      end
      default: begin
        dec_illegal   = 1'b1;
      end
    endcase
  end

  // Pipeline control: EX is held only while a load result is still missing
  logic in_load_wait;
  logic expiry;
  logic advance;

  assign in_load_wait = (state_reg == LOAD_WAIT) && wb_load_reg;
  assign stall        = in_load_wait && !dmem_valid;
  assign expiry       = stall && (cnt_reg == CNT_LAST);
  assign advance      = ex_valid && !stall;

  // RAW hazard detection, one comparator per register-file operand.
  // wb_we is never set for x0, so x0 can never match here.
  logic fw_hit [2];
  logic [SW-1:0] sel_out [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fw_hit[gi] = ex_valid
                        && (base_sel[gi] == `ALU_IN_MUX_RF)
                        && wb_valid_reg
                        && wb_we_reg
                        && (wb_rd_reg == rs_field[gi]);
      assign sel_out[gi] = !ex_valid  ? `ALU_IN_MUX_NULL :
                           fw_hit[gi] ? `ALU_IN_MUX_FW_WB :
                                        base_sel[gi];
    end
  endgenerate

  assign mux_1_sel    = sel_out[0];
  assign mux_2_sel    = sel_out[1];
  assign fw_rs1       = fw_hit[0];
  assign fw_rs2       = fw_hit[1];
  assign illegal_op   = ex_valid && dec_illegal;
  assign load_timeout = load_timeout_reg;

  // Writeback tracking: capture the advancing instruction, bubble when EX is
  // empty, hold on stall, and drop the abandoned load on expiry
  always_comb begin
    wb_valid_next = wb_valid_reg;
    wb_we_next    = wb_we_reg;
    wb_load_next  = wb_load_reg;
    wb_rd_next    = wb_rd_reg;
    if (expiry) begin
      wb_valid_next = 1'b0;
      wb_we_next    = 1'b0;
    end else if (advance) begin
      wb_valid_next = 1'b1;
      wb_rd_next    = rd_field;
      wb_load_next  = dec_load;
      wb_we_next    = dec_writes_rd && (rd_field != 5'd0) && !dec_illegal;
    end else if (!stall) begin
      wb_valid_next = 1'b0;
    end
  end

  // Load-wait FSM and timeout counter; a load advancing in the same cycle
  // that the previous one completes re-enters the wait with a fresh count
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    load_timeout_next = load_timeout_reg;
    case (state_reg)
      RUN: begin
        if (advance && dec_load) begin
          state_next = LOAD_WAIT;
          cnt_next   = '0;
        end
      end
      LOAD_WAIT: begin
        if (dmem_valid) begin
          cnt_next   = '0;
          state_next = (advance && dec_load) ? LOAD_WAIT : RUN;
        end else if (expiry) begin
          state_next        = RUN;
          cnt_next          = '0;
          load_timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= RUN;
      cnt_reg          <= '0;
      wb_valid_reg     <= 1'b0;
      wb_we_reg        <= 1'b0;
      wb_load_reg      <= 1'b0;
      wb_rd_reg        <= 5'd0;
      load_timeout_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      wb_valid_reg     <= wb_valid_next;
      wb_we_reg        <= wb_we_next;
      wb_load_reg      <= wb_load_next;
      wb_rd_reg        <= wb_rd_next;
      load_timeout_reg <= load_timeout_next;
    end
  end

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Self-checking bench for alu_operand_ctrl: a per-cycle vector table plus
// hand-written load-wait, timeout and async-reset sequences.

module tb_alu_operand_ctrl;

  localparam logic [2:0] S_RF     = 3'd0;
  localparam logic [2:0] S_PC     = 3'd1;
  localparam logic [2:0] S_NULL   = 3'd2;
  localparam logic [2:0] S_IMM_U  = 3'd3;
  localparam logic [2:0] S_IMM_UJ = 3'd4;
  localparam logic [2:0] S_IMM_I  = 3'd5;
  localparam logic [2:0] S_IMM_S  = 3'd6;
  localparam logic [2:0] S_FW     = 3'd7;

  localparam logic [31:0] I_LUI5   = 32'h123452B7;
  localparam logic [31:0] I_ADD6   = 32'h00028333;
  localparam logic [31:0] I_ADDI1  = 32'h00500093;
  localparam logic [31:0] I_ADD2   = 32'h00108133;
  localparam logic [31:0] I_ADDI0  = 32'h00700013;
  localparam logic [31:0] I_ADD200 = 32'h00000133;
  localparam logic [31:0] I_ILL7   = 32'h000003FF;
  localparam logic [31:0] I_ADD8   = 32'h00738433;
  localparam logic [31:0] I_JAL1   = 32'h000000EF;
  localparam logic [31:0] I_JALR0  = 32'h00008067;
  localparam logic [31:0] I_AUIPC3 = 32'h00000197;
  localparam logic [31:0] I_SW     = 32'h00312023;
  localparam logic [31:0] I_BEQ    = 32'h00018063;
  localparam logic [31:0] I_ADD4   = 32'h00018233;
  localparam logic [31:0] I_LW3    = 32'h0000A183;
  localparam logic [31:0] I_LW5    = 32'h0001A283;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ex_instruction;
  logic        ex_valid;
  logic        dmem_valid;
  logic [2:0]  mux_1_sel;
  logic [2:0]  mux_2_sel;
  logic        fw_rs1;
  logic        fw_rs2;
  logic        stall;
  logic        illegal_op;
  logic        load_timeout;

  int errors = 0;
  int checks = 0;

  alu_operand_ctrl #(.LOAD_TIMEOUT(16), .CNT_WIDTH(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_instruction (ex_instruction),
    .ex_valid       (ex_valid),
    .dmem_valid     (dmem_valid),
    .mux_1_sel      (mux_1_sel),
    .mux_2_sel      (mux_2_sel),
    .fw_rs1         (fw_rs1),
    .fw_rs2         (fw_rs2),
    .stall          (stall),
    .illegal_op     (illegal_op),
    .load_timeout   (load_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        v;
    logic        d;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic        f1;
    logic        f2;
    logic        st;
    logic        il;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [31:0] instr, input logic v, input logic d,
                              input logic [2:0] s1, input logic [2:0] s2,
                              input logic f1, input logic f2, input logic st, input logic il);
    vec_t r;
    r.instr = instr; r.v = v; r.d = d; r.s1 = s1; r.s2 = s2;
    r.f1 = f1; r.f2 = f2; r.st = st; r.il = il;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, sample 2 time units later
  task automatic cyc(input logic [31:0] instr, input logic v, input logic d);
    @(negedge clk);
    ex_instruction = instr;
    ex_valid       = v;
    dmem_valid     = d;
    #2;
  endtask

  initial begin
    vecs[0]  = mk(I_LUI5,   1, 0, S_NULL, S_IMM_U,  0, 0, 0, 0);
    vecs[1]  = mk(I_ADD6,   1, 0, S_FW,   S_RF,     1, 0, 0, 0);
    vecs[2]  = mk(I_ADDI1,  1, 0, S_RF,   S_IMM_I,  0, 0, 0, 0);
    vecs[3]  = mk(I_ADD2,   1, 0, S_FW,   S_FW,     1, 1, 0, 0);
    vecs[4]  = mk(I_ADDI1,  1, 0, S_RF,   S_IMM_I,  0, 0, 0, 0);
    vecs[5]  = mk(I_ADD2,   0, 0, S_NULL, S_NULL,   0, 0, 0, 0);
    vecs[6]  = mk(I_ADD2,   1, 0, S_RF,   S_RF,     0, 0, 0, 0);
    vecs[7]  = mk(I_ADDI0,  1, 0, S_RF,   S_IMM_I,  0, 0, 0, 0);
    vecs[8]  = mk(I_ADD200, 1, 0, S_RF,   S_RF,     0, 0, 0, 0);
    vecs[9]  = mk(I_ILL7,   1, 0, S_NULL, S_NULL,   0, 0, 0, 1);
    vecs[10] = mk(I_ADD8,   1, 0, S_RF,   S_RF,     0, 0, 0, 0);
    vecs[11] = mk(I_JAL1,   1, 0, S_PC,   S_IMM_UJ, 0, 0, 0, 0);
    vecs[12] = mk(I_JALR0,  1, 0, S_FW,   S_IMM_I,  1, 0, 0, 0);
    vecs[13] = mk(I_AUIPC3, 1, 0, S_PC,   S_IMM_U,  0, 0, 0, 0);
    vecs[14] = mk(I_SW,     1, 0, S_RF,   S_IMM_S,  0, 0, 0, 0);
    vecs[15] = mk(I_BEQ,    1, 0, S_RF,   S_RF,     0, 0, 0, 0);
    vecs[16] = mk(I_ADD4,   1, 0, S_RF,   S_RF,     0, 0, 0, 0);
    vecs[17] = mk(I_LW3,    1, 0, S_RF,   S_IMM_I,  0, 0, 0, 0);
    vecs[18] = mk(I_ADD4,   1, 0, S_FW,   S_RF,     1, 0, 1, 0);
    vecs[19] = mk(I_ADD4,   1, 0, S_FW,   S_RF,     1, 0, 1, 0);
    vecs[20] = mk(I_ADD4,   1, 0, S_FW,   S_RF,     1, 0, 1, 0);
    vecs[21] = mk(I_ADD4,   1, 1, S_FW,   S_RF,     1, 0, 0, 0);
    vecs[22] = mk(I_LUI5,   1, 0, S_NULL, S_IMM_U,  0, 0, 0, 0);
    vecs[23] = mk(I_LW3,    1, 0, S_RF,   S_IMM_I,  0, 0, 0, 0);
    vecs[24] = mk(I_LW5,    1, 0, S_FW,   S_IMM_I,  1, 0, 1, 0);
    vecs[25] = mk(I_LW5,    1, 1, S_FW,   S_IMM_I,  1, 0, 0, 0);
    vecs[26] = mk(I_ADD6,   1, 0, S_FW,   S_RF,     1, 0, 1, 0);
    vecs[27] = mk(I_ADD6,   1, 1, S_FW,   S_RF,     1, 0, 0, 0);
    vecs[28] = mk(I_ADD6,   0, 1, S_NULL, S_NULL,   0, 0, 0, 0);

    rst_n = 1'b0; ex_instruction = 32'h0; ex_valid = 1'b0; dmem_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("reset stall", int'(stall), 0);
    chk("reset load_timeout", int'(load_timeout), 0);
    chk("reset sel1", int'(mux_1_sel), int'(S_NULL));
    chk("reset sel2", int'(mux_2_sel), int'(S_NULL));
    @(negedge clk);
    rst_n = 1'b1;

    // Per-cycle vector table
    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].instr, vecs[i].v, vecs[i].d);
      $display("vec %0d instr=%08h v=%0d d=%0d -> sel=%0d/%0d fw=%0d%0d stall=%0d ill=%0d",
               i, vecs[i].instr, vecs[i].v, vecs[i].d, mux_1_sel, mux_2_sel,
               fw_rs1, fw_rs2, stall, illegal_op);
      chk($sformatf("vec%0d sel1", i),  int'(mux_1_sel),  int'(vecs[i].s1));
      chk($sformatf("vec%0d sel2", i),  int'(mux_2_sel),  int'(vecs[i].s2));
      chk($sformatf("vec%0d fw1", i),   int'(fw_rs1),     int'(vecs[i].f1));
      chk($sformatf("vec%0d fw2", i),   int'(fw_rs2),     int'(vecs[i].f2));
      chk($sformatf("vec%0d stall", i), int'(stall),      int'(vecs[i].st));
      chk($sformatf("vec%0d ill", i),   int'(illegal_op), int'(vecs[i].il));
    end

    // dmem_valid arriving on the last wait cycle beats the timeout
    cyc(I_LW3, 1, 0);
    chk("win lw stall", int'(stall), 0);
    for (int k = 0; k < 15; k++) begin
      cyc(I_ADD4, 1, 0);
      chk($sformatf("win wait%0d stall", k), int'(stall), 1);
    end
    cyc(I_ADD4, 1, 1);
    $display("dmem-vs-expiry: stall=%0d sel1=%0d", stall, mux_1_sel);
    chk("win release stall", int'(stall), 0);
    chk("win release sel1", int'(mux_1_sel), int'(S_FW));
    cyc(I_ADD4, 0, 0);
    chk("win no timeout", int'(load_timeout), 0);
    chk("win run stall", int'(stall), 0);

    // Load whose data never arrives: 16 stall cycles then abandon
    cyc(I_LW3, 1, 0);
    chk("to lw stall", int'(stall), 0);
    for (int k = 0; k < 16; k++) begin
      cyc(I_ADD4, 1, 0);
      chk($sformatf("to wait%0d stall", k), int'(stall), 1);
      chk($sformatf("to wait%0d flag", k), int'(load_timeout), 0);
    end
    cyc(I_ADD4, 1, 0);
    $display("timeout: stall=%0d load_timeout=%0d sel=%0d/%0d fw1=%0d",
             stall, load_timeout, mux_1_sel, mux_2_sel, fw_rs1);
    chk("to after stall", int'(stall), 0);
    chk("to after flag", int'(load_timeout), 1);
    chk("to after sel1", int'(mux_1_sel), int'(S_RF));
    chk("to after sel2", int'(mux_2_sel), int'(S_RF));
    chk("to after fw1", int'(fw_rs1), 0);

    // Asynchronous reset in the middle of a load wait
    cyc(I_LW3, 1, 0);
    chk("rst lw flag sticky", int'(load_timeout), 1);
    for (int k = 0; k < 5; k++) begin
      cyc(I_ADD4, 1, 0);
      chk($sformatf("rst wait%0d stall", k), int'(stall), 1);
    end
    rst_n = 1'b0;
    #1;
    $display("async reset: stall=%0d load_timeout=%0d", stall, load_timeout);
    chk("rst async stall", int'(stall), 0);
    chk("rst async flag", int'(load_timeout), 0);
    chk("rst async sel1", int'(mux_1_sel), int'(S_RF));
    @(negedge clk);
    rst_n = 1'b1;
    cyc(I_ADD4, 1, 0);
    chk("rst after stall", int'(stall), 0);
    chk("rst after fw1", int'(fw_rs1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
